simd_image_writer: RTL

N-lane write-back engine for the downscale path. On `start` it snapshots a finished `IMG_H`×`IMG_W` 8-bit image, such as the downscaler's `image_out`, and drains it to an output image memory in raster order. It issues N consecutive pixel writes per group, using a per-lane request/acknowledge handshake. It is the write-side counterpart of the N-lane SIMD read port (`rd_req`/`rd_addr`/`rd_valid`/`rd_data`) used to fetch source images.

---
 rtl/simd_image_writer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/simd_image_writer.sv
// -----------------------------------------------------------------------------
// simd_image_writer
//
// N-lane write-back engine. A start pulse snapshots an IMG_H x IMG_W 8-bit
// image into an internal buffer. The buffer is then drained to an output
// memory in raster order, as groups of N consecutive pixels. Each group is
// issued on N independent request/acknowledge lanes.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   start      single-cycle transfer request; only honoured in IDLE
//   image_in   source image, sampled only on the edge that accepts start
//   busy       high while a transfer is issuing or signalling completion
//   done       one-cycle completion pulse
//   wr_req     per-lane write request
//   wr_addr    per-lane write address (BASE_ADDR + raster index)
//   wr_data    per-lane write data
//   wr_ack     per-lane acknowledge from the memory
//   dbg_state  current FSM state (IDLE=0, ISSUE=1, DONE=2)
//
// Lane handshake: a write on lane L transfers at a rising edge where
// wr_req[L] and wr_ack[L] are both 1. While wr_req[L] is high and not yet
// acknowledged, wr_addr[L] and wr_data[L] hold steady. After the accepting
// edge, wr_req[L] drops until the next group is presented. wr_ack[L] is
// ignored whenever wr_req[L] is 0. Lanes complete in any order. The group
// advances on the edge that accepts its last outstanding lane, and the next
// group is presented in the very next cycle.
//
// All outputs come straight from flops. Each cycle's values are computed
// from the next-state decode, so wr_ack never reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module simd_image_writer #(
    parameter int IMG_H     = 16,
    parameter int IMG_W     = 16,
    parameter int N         = 4,
    parameter int ADDR_BITS = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           image_in [0:IMG_H-1][0:IMG_W-1],
    output logic                 busy,
    output logic                 done,
    output logic [N-1:0]         wr_req,
    output logic [ADDR_BITS-1:0] wr_addr  [0:N-1],
    output logic [7:0]           wr_data  [0:N-1],
    input  logic [N-1:0]         wr_ack,
    output logic [1:0]           dbg_state
);

    localparam int SIZE  = IMG_H * IMG_W;
    // idx must be able to hold the largest group base plus N for the
    // "another group left?" comparison.
    localparam int IDX_W = $clog2(SIZE + N + 1);
    localparam int PIX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_n;
    logic [IDX_W-1:0]     idx_q, idx_n;
    logic [N-1:0]         lane_done_q, lane_done_n;
    logic [N-1:0]         active_q;
    logic [N-1:0]         acked;
    logic                 load;

    logic [7:0]           img_flat [0:SIZE-1];
    logic [7:0]           pix_buf  [0:SIZE-1];

    logic [N-1:0]         req_n;
    logic [ADDR_BITS-1:0] addr_n [0:N-1];
    logic [7:0]           data_n [0:N-1];

    assign dbg_state = state_q;

    // Raster-order view of the input image.
    always_comb begin
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                img_flat[r*IMG_W + c] = image_in[r][c];
            end
        end
    end

    // Snapshot buffer. It only changes on an accepted start, so it needs no
    // reset.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < SIZE; i++) begin
                pix_buf[i] <= img_flat[i];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_n     = state_q;
        idx_n       = idx_q;
        lane_done_n = lane_done_q;
        load        = 1'b0;
        acked       = wr_req & wr_ack;
        for (int l = 0; l < N; l++) begin
            active_q[l] = (int'(idx_q) + l) < SIZE;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load        = 1'b1;
                    idx_n       = '0;
                    lane_done_n = '0;
                    state_n     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                lane_done_n = lane_done_q | acked;
                // Inactive tail lanes count as finished.
                if (&(lane_done_n | ~active_q)) begin
                    if ((int'(idx_q) + N) < SIZE) begin
                        idx_n       = idx_q + IDX_W'(N);
                        lane_done_n = '0;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Values the output flops take at the next edge, derived from next state.
    // On the load cycle the buffer is not written yet, so data comes from
    // image_in directly.
    always_comb begin
        int p;
        p = 0;
        for (int l = 0; l < N; l++) begin
            p         = int'(idx_n) + l;
            req_n[l]  = 1'b0;
            addr_n[l] = '0;
            data_n[l] = '0;
            if ((state_n == S_ISSUE) && (p < SIZE)) begin
                req_n[l]  = ~lane_done_n[l];
                addr_n[l] = ADDR_BITS'(BASE_ADDR + p);
                data_n[l] = load ? img_flat[PIX_W'(p)] : pix_buf[PIX_W'(p)];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            lane_done_q <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wr_req      <= '0;
            for (int l = 0; l < N; l++) begin
                wr_addr[l] <= '0;
                wr_data[l] <= '0;
            end
        end else begin
            state_q     <= state_n;
            idx_q       <= idx_n;
            lane_done_q <= lane_done_n;
            busy        <= (state_n != S_IDLE);
            done        <= (state_n == S_DONE);
            wr_req      <= req_n;
            for (int l = 0; l < N; l++) begin
                wr_addr[l] <= addr_n[l];
                wr_data[l] <= data_n[l];
            end
        end
    end

endmodule
